regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (RegWrite / write_reg_addr / write_reg_data) between two writers.
  - The in-order pipeline writeback (WB).
  - A long-latency unit (LU, e.g. multiplier/divider) that returns results out of band over a valid/ready handshake.
- Sits between the WB stage / LU and the register file.
- Registers the write-port signals and filters x0 writes.
- Guarantees LU forward progress through a starvation counter.
- Resolves same-address collisions in program order.

---
 rtl/regfile_wb_arbiter_if.sv | 31 +++
 rtl/regfile_wb_arbiter.sv | 61 ++++++
 tb/tb_regfile_wb_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - WB / LU writer handshakes and register-file write port
interface regfile_wb_arbiter_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_DATA_WIDTH = 64
);
    logic                      wb_valid;
    logic [REG_ADDR_WIDTH-1:0] wb_addr;
    logic [REG_DATA_WIDTH-1:0] wb_data;
    logic                      wb_stall;
    logic                      lu_valid;
    logic [REG_ADDR_WIDTH-1:0] lu_addr;
    logic [REG_DATA_WIDTH-1:0] lu_data;
    logic                      lu_ready;
    logic                      RegWrite;
    logic [REG_ADDR_WIDTH-1:0] write_reg_addr;
    logic [REG_DATA_WIDTH-1:0] write_reg_data;

    modport master (
        output wb_valid, wb_addr, wb_data,
        output lu_valid, lu_addr, lu_data,
        input  wb_stall, lu_ready,
        input  RegWrite, write_reg_addr, write_reg_data
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data,
        input  lu_valid, lu_addr, lu_data,
        output wb_stall, lu_ready,
        output RegWrite, write_reg_addr, write_reg_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port between WB and a long-latency unit
module regfile_wb_arbiter #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_DATA_WIDTH = 64,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic clk,
    input  logic reset,
    regfile_wb_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;
    logic          wbq;
    logic          luq;
    logic          lu_x0;
    logic          force_lu;
    logic          lu_grant;
    logic          wb_grant;

    always_comb begin
        wbq      = bus.wb_valid && (bus.wb_addr != '0);
        luq      = bus.lu_valid && (bus.lu_addr != '0);
        lu_x0    = bus.lu_valid && (bus.lu_addr == '0);
        // LU result is older than the WB one: same-address writes must land LU first
        force_lu = wbq && luq && ((bus.wb_addr == bus.lu_addr) || (starve_cnt == LIMIT));
        lu_grant = !reset && luq && (!wbq || force_lu);
        wb_grant = !reset && wbq && !lu_grant;
    end

    assign bus.lu_ready = !reset && (lu_grant || lu_x0);
    assign bus.wb_stall = !reset && wbq && lu_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.RegWrite       <= 1'b0;
            bus.write_reg_addr <= '0;
            bus.write_reg_data <= '0;
            starve_cnt         <= '0;
        end else begin
            if (lu_grant) begin
                bus.RegWrite       <= 1'b1;
                bus.write_reg_addr <= bus.lu_addr;
                bus.write_reg_data <= bus.lu_data;
            end else if (wb_grant) begin
                bus.RegWrite       <= 1'b1;
                bus.write_reg_addr <= bus.wb_addr;
                bus.write_reg_data <= bus.wb_data;
            end else begin
                bus.RegWrite <= 1'b0;
            end

            if (!luq || lu_grant) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   x0_writes;

    regfile_wb_arbiter_if #(.REG_ADDR_WIDTH(5), .REG_DATA_WIDTH(64)) bus ();

    regfile_wb_arbiter #(
        .REG_ADDR_WIDTH(5),
        .REG_DATA_WIDTH(64),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && bus.RegWrite && (bus.write_reg_addr == 5'd0)) x0_writes++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_valid = 1'b0;
        bus.lu_valid = 1'b0;
    endtask

    task automatic chk_write(input string name, input logic [4:0] a, input logic [63:0] d);
        tests++;
        if (bus.RegWrite !== 1'b1 || bus.write_reg_addr !== a || bus.write_reg_data !== d) begin
            fails++;
            $display("FAIL %s: got we=%b addr=%0d data=%h, want we=1 addr=%0d data=%h",
                     name, bus.RegWrite, bus.write_reg_addr, bus.write_reg_data, a, d);
        end
    endtask

    task automatic chk_hs(input string name, input logic rdy, input logic stl);
        tests++;
        if (bus.lu_ready !== rdy || bus.wb_stall !== stl) begin
            fails++;
            $display("FAIL %s: got lu_ready=%b wb_stall=%b, want lu_ready=%b wb_stall=%b",
                     name, bus.lu_ready, bus.wb_stall, rdy, stl);
        end
    endtask

    task automatic chk_nowrite(input string name);
        tests++;
        if (bus.RegWrite !== 1'b0) begin
            fails++;
            $display("FAIL %s: got RegWrite=%b, want 0", name, bus.RegWrite);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 64'h33;
        bus.lu_valid = 1'b1; bus.lu_addr = 5'd4; bus.lu_data = 64'h44;
        step();
        tests++;
        if (bus.RegWrite !== 1'b0 || bus.write_reg_addr !== 5'd0 || bus.write_reg_data !== 64'd0) begin
            fails++;
            $display("FAIL reset_outputs: got we=%b addr=%0d data=%h, want 0 0 0",
                     bus.RegWrite, bus.write_reg_addr, bus.write_reg_data);
        end
        chk_hs("reset_handshake", 1'b0, 1'b0);
        bus.lu_valid = 1'b0;
        reset = 1'b0;
        bus.wb_addr = 5'd2; bus.wb_data = 64'h22;
        step();
        chk_write("pre_reset_write", 5'd2, 64'h22);
        bus.wb_addr = 5'd3; bus.wb_data = 64'h33;
        #2 reset = 1'b1;
        #1;
        tests++;
        if (bus.RegWrite !== 1'b0 || bus.write_reg_addr !== 5'd0 || bus.write_reg_data !== 64'd0) begin
            fails++;
            $display("FAIL midstream_reset: got we=%b addr=%0d data=%h, want 0 0 0",
                     bus.RegWrite, bus.write_reg_addr, bus.write_reg_data);
        end
        step();
        #3 reset = 1'b0;
        #1 chk_nowrite("after_release_before_edge");
        step();
        chk_write("first_write_after_reset", 5'd3, 64'h33);
        idle();
        step();
    endtask

    task automatic test_wb_only();
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 64'h11;
        #1 chk_hs("wb_only_hs", 1'b0, 1'b0);
        step();
        chk_write("wb_only_write", 5'd5, 64'h11);
        idle();
        step();
        chk_nowrite("wb_only_idle");
        tests++;
        if (bus.write_reg_addr !== 5'd5 || bus.write_reg_data !== 64'h11) begin
            fails++;
            $display("FAIL idle_hold: got addr=%0d data=%h, want 5 11",
                     bus.write_reg_addr, bus.write_reg_data);
        end
    endtask

    task automatic test_starvation();
        bus.lu_valid = 1'b1; bus.lu_addr = 5'd9; bus.lu_data = 64'hAB;
        bus.wb_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wb_addr = 5'(i + 1); bus.wb_data = 64'h100 + 64'(i);
            #1 chk_hs("starve_denied", 1'b0, 1'b0);
            step();
            chk_write("starve_wb_write", 5'(i + 1), 64'h100 + 64'(i));
        end
        bus.wb_addr = 5'd5; bus.wb_data = 64'h104;
        #1 chk_hs("starve_forced", 1'b1, 1'b1);
        step();
        chk_write("starve_lu_write", 5'd9, 64'hAB);
        bus.lu_valid = 1'b0;
        #1 chk_hs("starve_held_wb", 1'b0, 1'b0);
        step();
        chk_write("starve_held_write", 5'd5, 64'h104);
        idle();
        step();
    endtask

    task automatic test_collision();
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 64'h2;
        bus.lu_valid = 1'b1; bus.lu_addr = 5'd7; bus.lu_data = 64'h1;
        #1 chk_hs("collision_hs", 1'b1, 1'b1);
        step();
        chk_write("collision_lu_first", 5'd7, 64'h1);
        bus.lu_valid = 1'b0;
        #1 chk_hs("collision_wb_release", 1'b0, 1'b0);
        step();
        chk_write("collision_wb_second", 5'd7, 64'h2);
        idle();
        step();
        chk_nowrite("collision_idle");
    endtask

    task automatic test_x0();
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 64'hDEAD;
        bus.lu_valid = 1'b1; bus.lu_addr = 5'd4; bus.lu_data = 64'h33;
        #1 chk_hs("x0_wb_hs", 1'b1, 1'b0);
        step();
        chk_write("x0_lu_write", 5'd4, 64'h33);
        bus.lu_valid = 1'b0;
        #1 chk_hs("x0_wb_alone", 1'b0, 1'b0);
        step();
        chk_nowrite("x0_wb_no_write");
        bus.wb_addr = 5'd6; bus.wb_data = 64'h66;
        bus.lu_valid = 1'b1; bus.lu_addr = 5'd0; bus.lu_data = 64'hBEEF;
        #1 chk_hs("x0_lu_hs", 1'b1, 1'b0);
        step();
        chk_write("x0_lu_wb_write", 5'd6, 64'h66);
        idle();
        step();
        chk_nowrite("x0_idle");
        tests++;
        if (x0_writes !== 0) begin
            fails++;
            $display("FAIL no_x0_write: got %0d x0 writes, want 0", x0_writes);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        x0_writes = 0;
        bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.lu_valid = 1'b0; bus.lu_addr = '0; bus.lu_data = '0;
        test_reset();
        test_wb_only();
        test_starvation();
        test_collision();
        test_x0();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
